neuron_layer_evaluator: RTL and testbench

Bus master for the neuron dual-port RAM. It computes one neuron output per command: it sweeps a contiguous range of input activations on the RAM read port and multiplies each by a signed weight taken from a valid/ready stream. The products are accumulated, then ReLU, right shift and saturation are applied, and the 8-bit result is written back through the RAM write port. It sits between the network sequencer, which issues commands, and the neuron RAM.

---
 rtl/neuron_layer_evaluator.sv | 142 ++++++++++++++
 tb/tb_neuron_layer_evaluator.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_layer_evaluator.sv
`default_nettype none
// ============================================================================
// Module   : neuron_layer_evaluator
// Brief    : Computes one neuron output (MAC over a RAM activation range with
//            streamed signed weights, then ReLU/shift/saturate) per command.
// Revision : 1.0
// ============================================================================
module neuron_layer_evaluator #(
    parameter int DATA_BUS_WIDTH    = 8,
    parameter int ADDRESS_BUS_WIDTH = 16,
    parameter int ACC_WIDTH         = 24,
    parameter int SHIFT             = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [ADDRESS_BUS_WIDTH-1:0] in_base,
    input  logic [ADDRESS_BUS_WIDTH-1:0] count,
    input  logic [ADDRESS_BUS_WIDTH-1:0] out_addr,
    input  logic [DATA_BUS_WIDTH-1:0]    weight,
    input  logic                         weight_valid,
    output logic                         weight_ready,
    output logic [ADDRESS_BUS_WIDTH-1:0] ram_read_address,
    output logic                         ram_oe,
    input  logic [DATA_BUS_WIDTH-1:0]    ram_read_data,
    output logic [ADDRESS_BUS_WIDTH-1:0] ram_write_address,
    output logic [DATA_BUS_WIDTH-1:0]    ram_write_data,
    output logic                         ram_wre,
    output logic                         busy,
    output logic                         done
);

    localparam int PROD_WIDTH = 2 * DATA_BUS_WIDTH + 1;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_accum = 2'd1;
    localparam logic [1:0] c_st_write = 2'd2;

    localparam logic [ADDRESS_BUS_WIDTH-1:0] c_addr_zero = '0;
    localparam logic [ADDRESS_BUS_WIDTH-1:0] c_idx_one   = ADDRESS_BUS_WIDTH'(1);

    logic [1:0]                   r_state;
    logic [ADDRESS_BUS_WIDTH-1:0] r_base;
    logic [ADDRESS_BUS_WIDTH-1:0] r_count;
    logic [ADDRESS_BUS_WIDTH-1:0] r_out_addr;
    logic [ADDRESS_BUS_WIDTH-1:0] r_idx;
    logic signed [ACC_WIDTH-1:0]  r_acc;
    logic                         r_done;

    logic signed [PROD_WIDTH-1:0] w_act_ext;
    logic signed [PROD_WIDTH-1:0] w_wt_ext;
    logic signed [PROD_WIDTH-1:0] w_prod;
    logic signed [ACC_WIDTH-1:0]  w_prod_ext;
    logic signed [ACC_WIDTH-1:0]  w_shifted;
    logic [DATA_BUS_WIDTH-1:0]    w_sat_data;
    logic                         w_hs;
    logic                         w_last;

    // Activation is unsigned, weight signed; both widened so the product is exact.
    assign w_act_ext  = {{(DATA_BUS_WIDTH + 1){1'b0}}, ram_read_data};
    assign w_wt_ext   = {{(DATA_BUS_WIDTH + 1){weight[DATA_BUS_WIDTH-1]}}, weight};
    assign w_prod     = w_act_ext * w_wt_ext;
    assign w_prod_ext = {{(ACC_WIDTH - PROD_WIDTH){w_prod[PROD_WIDTH-1]}}, w_prod};
    assign w_shifted  = r_acc >>> SHIFT;

    assign w_hs   = (r_state == c_st_accum) && weight_valid;
    assign w_last = ((r_idx + c_idx_one) == r_count);

    always_comb begin
        w_sat_data = w_shifted[DATA_BUS_WIDTH-1:0];
        if (w_shifted[ACC_WIDTH-1]) begin
            w_sat_data = '0;
        end else if (|w_shifted[ACC_WIDTH-2:DATA_BUS_WIDTH]) begin
            w_sat_data = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_base     <= '0;
            r_count    <= '0;
            r_out_addr <= '0;
            r_idx      <= '0;
            r_acc      <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= (r_state == c_st_write);
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_base     <= in_base;
                        r_count    <= count;
                        r_out_addr <= out_addr;
                        r_idx      <= '0;
                        r_acc      <= '0;
                        r_state    <= (count == c_addr_zero) ? c_st_write : c_st_accum;
                    end
                end
                c_st_accum: begin
                    if (w_hs) begin
                        r_acc <= r_acc + w_prod_ext;
                        r_idx <= r_idx + c_idx_one;
                        if (w_last) begin
                            r_state <= c_st_write;
                        end
                    end
                end
                c_st_write: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    always_comb begin
        weight_ready      = 1'b0;
        ram_oe            = 1'b0;
        ram_read_address  = '0;
        ram_wre           = 1'b0;
        ram_write_address = '0;
        ram_write_data    = '0;
        if (r_state == c_st_accum) begin
            weight_ready     = 1'b1;
            ram_oe           = 1'b1;
            ram_read_address = r_base + r_idx;
        end
        if (r_state == c_st_write) begin
            ram_wre           = 1'b1;
            ram_write_address = r_out_addr;
            ram_write_data    = w_sat_data;
        end
    end

    assign busy = (r_state != c_st_idle);
    assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_neuron_layer_evaluator.sv
`default_nettype none
// ============================================================================
// Module   : tb_neuron_layer_evaluator
// Brief    : Directed self-checking bench with a behavioural neuron RAM.
// Revision : 1.0
// ============================================================================
module tb_neuron_layer_evaluator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        start_s = 1'b0;
    logic [15:0] in_base = '0;
    logic [15:0] count = '0;
    logic [15:0] out_addr = '0;
    logic [7:0]  weight = '0;
    logic        weight_valid = 1'b0;

    logic        wr0, oe0, wre0, busy0, done0;
    logic [15:0] ra0, wa0;
    logic [7:0]  rd0, wd0;
    logic        wr1, oe1, wre1, busy1, done1;
    logic [15:0] ra1, wa1;
    logic [7:0]  rd1, wd1;

    logic [7:0]  mem [0:65535];
    logic        sel = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    // Results captured by run_cmd
    int          wre_cyc, done_cyc, wre_n;
    logic [15:0] wa_seen;
    logic        ready_seen, busy_first, busy_at_done;
    logic [15:0] rd_addrs [0:7];
    logic [7:0]  wts [0:7];

    always #5 clk = ~clk;

    assign rd0 = mem[ra0];
    assign rd1 = mem[ra1];

    always @(posedge clk) begin
        if (wre0) mem[wa0] <= wd0;
        if (wre1) mem[wa1] <= wd1;
    end

    neuron_layer_evaluator #(.SHIFT(0)) dut (
        .clk(clk), .rst(rst), .start(start), .in_base(in_base), .count(count),
        .out_addr(out_addr), .weight(weight), .weight_valid(weight_valid),
        .weight_ready(wr0), .ram_read_address(ra0), .ram_oe(oe0),
        .ram_read_data(rd0), .ram_write_address(wa0), .ram_write_data(wd0),
        .ram_wre(wre0), .busy(busy0), .done(done0)
    );

    neuron_layer_evaluator #(.SHIFT(8)) dut_shift (
        .clk(clk), .rst(rst), .start(start_s), .in_base(in_base), .count(count),
        .out_addr(out_addr), .weight(weight), .weight_valid(weight_valid),
        .weight_ready(wr1), .ram_read_address(ra1), .ram_oe(oe1),
        .ram_read_data(rd1), .ram_write_address(wa1), .ram_write_data(wd1),
        .ram_wre(wre1), .busy(busy1), .done(done1)
    );

    wire         m_ready = sel ? wr1 : wr0;
    wire [15:0]  m_ra    = sel ? ra1 : ra0;
    wire         m_wre   = sel ? wre1 : wre0;
    wire [15:0]  m_wa    = sel ? wa1 : wa0;
    wire         m_busy  = sel ? busy1 : busy0;
    wire         m_done  = sel ? done1 : done0;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one command, feed weights (optional stall after first handshake),
    // optionally re-pulse start while busy, and record timing of wre/done.
    task automatic run_cmd(input logic [15:0] base, input logic [15:0] cnt,
                           input logic [15:0] oaddr, input int stall_n,
                           input bit intrude);
        int hs = 0;
        int stall_left = 0;
        wre_cyc = -1; done_cyc = -1; wre_n = 0; wa_seen = '0;
        ready_seen = 1'b0; busy_first = 1'b0; busy_at_done = 1'b1;
        in_base = base; count = cnt; out_addr = oaddr;
        if (sel) start_s = 1'b1; else start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; start_s = 1'b0;
        in_base = 16'h5555; count = 16'd7; out_addr = 16'h0300;
        for (int k = 1; k <= 60; k++) begin
            if (k == 1) busy_first = m_busy;
            if (m_wre) begin wre_n++; wre_cyc = k; wa_seen = m_wa; end
            if (m_done) begin done_cyc = k; busy_at_done = m_busy; end
            if (m_ready) ready_seen = 1'b1;
            weight_valid = 1'b0;
            weight = 8'h55;
            if (m_ready && hs < int'(cnt)) begin
                if (stall_left > 0) begin
                    stall_left--;
                end else begin
                    weight_valid = 1'b1;
                    weight = wts[hs];
                    rd_addrs[hs] = m_ra;
                    hs++;
                    if (hs == 1) stall_left = stall_n;
                end
            end
            start = intrude && (k == 2) && !sel;
            if (done_cyc >= 0) break;
            @(posedge clk); #1;
        end
        start = 1'b0;
        weight_valid = 1'b0;
        if (done_cyc < 0) check_value("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic seen_bad;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0010] = 8'd10; mem[16'h0011] = 8'd20; mem[16'h0012] = 8'd30;
        mem[16'h0020] = 8'd255; mem[16'h0021] = 8'd255;
        mem[16'h0022] = 8'd255; mem[16'h0023] = 8'd255;
        mem[16'h0030] = 8'd100;
        mem[16'hFFFF] = 8'd3; mem[16'h0000] = 8'd4;
        mem[16'h0100] = 8'hAA; mem[16'h0110] = 8'hAA; mem[16'h0120] = 8'hAA;
        mem[16'h0130] = 8'hAA; mem[16'h0140] = 8'hAA; mem[16'h0150] = 8'hAA;
        mem[16'h0160] = 8'hAA; mem[16'h0180] = 8'hAA; mem[16'h0190] = 8'hAA;
        mem[16'h0200] = 8'hAA; mem[16'h0300] = 8'hAA;

        repeat (3) @(posedge clk);
        #1;
        check_value("rst_outputs", {wr0, oe0, wre0, busy0, done0}, 5'b0);
        check_value("rst_addrs", {ra0, wa0}, 32'h0);
        check_value("rst_wdata", wd0, 8'h00);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic MAC: 10*2 + 20*-1 + 30*3 = 90
        wts[0] = 8'd2; wts[1] = 8'hFF; wts[2] = 8'd3;
        run_cmd(16'h0010, 16'd3, 16'h0100, 0, 1'b0);
        check_value("basic_result", mem[16'h0100], 8'd90);
        check_value("basic_wre_cyc", wre_cyc, 4);
        check_value("basic_done_cyc", done_cyc, 5);
        check_value("basic_wre_count", wre_n, 1);
        check_value("basic_waddr", wa_seen, 16'h0100);
        check_value("basic_busy_first", busy_first, 1'b1);
        check_value("basic_busy_at_done", busy_at_done, 1'b0);
        check_value("basic_rd_addr2", rd_addrs[2], 16'h0012);

        // ReLU: 100 * -5 = -500 -> 0
        wts[0] = 8'hFB;
        run_cmd(16'h0030, 16'd1, 16'h0130, 0, 1'b0);
        check_value("relu_result", mem[16'h0130], 8'd0);
        check_value("relu_done_cyc", done_cyc, 3);

        // Saturation: 4 * 255 * 127 = 129540 -> 255
        for (int i = 0; i < 4; i++) wts[i] = 8'd127;
        run_cmd(16'h0020, 16'd4, 16'h0140, 0, 1'b0);
        check_value("sat_result", mem[16'h0140], 8'd255);
        check_value("sat_done_cyc", done_cyc, 6);

        // Address wrap: 3*1 + 4*1 = 7
        wts[0] = 8'd1; wts[1] = 8'd1;
        run_cmd(16'hFFFF, 16'd2, 16'h0150, 0, 1'b0);
        check_value("wrap_addr0", rd_addrs[0], 16'hFFFF);
        check_value("wrap_addr1", rd_addrs[1], 16'h0000);
        check_value("wrap_result", mem[16'h0150], 8'd7);

        // count = 0: writes 0 immediately
        run_cmd(16'h0010, 16'd0, 16'h0160, 0, 1'b0);
        check_value("zero_result", mem[16'h0160], 8'd0);
        check_value("zero_wre_cyc", wre_cyc, 1);
        check_value("zero_done_cyc", done_cyc, 2);
        check_value("zero_no_ready", ready_seen, 1'b0);

        // Stall of 3 cycles after first handshake
        wts[0] = 8'd2; wts[1] = 8'hFF; wts[2] = 8'd3;
        run_cmd(16'h0010, 16'd3, 16'h0110, 3, 1'b0);
        check_value("stall_result", mem[16'h0110], 8'd90);
        check_value("stall_done_cyc", done_cyc, 8);
        check_value("stall_wre_count", wre_n, 1);

        // start while busy with different operands is ignored
        run_cmd(16'h0010, 16'd3, 16'h0120, 0, 1'b1);
        check_value("busy_start_result", mem[16'h0120], 8'd90);
        check_value("busy_start_other", mem[16'h0300], 8'hAA);
        check_value("busy_start_done", done_cyc, 5);

        // SHIFT=8 instance: 255*127 = 32385 >> 8 = 126
        sel = 1'b1;
        wts[0] = 8'd127;
        run_cmd(16'h0020, 16'd1, 16'h0200, 0, 1'b0);
        check_value("shift_result", mem[16'h0200], 8'd126);
        sel = 1'b0;

        // Reset in the middle of ACCUM
        in_base = 16'h0010; count = 16'd3; out_addr = 16'h0180; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; weight_valid = 1'b1; weight = 8'd2;
        @(posedge clk); #1;
        rst = 1'b1; weight = 8'hFF;
        @(posedge clk); #1;
        check_value("midrst_outputs", {wr0, oe0, wre0, busy0, done0}, 5'b0);
        check_value("midrst_addrs", {ra0, wa0}, 32'h0);
        rst = 1'b0; weight_valid = 1'b0;
        seen_bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (wre0 || done0 || busy0) seen_bad = 1'b1;
        end
        check_value("midrst_quiet", seen_bad, 1'b0);
        check_value("midrst_no_write", mem[16'h0180], 8'hAA);
        wts[0] = 8'd3;
        run_cmd(16'h0010, 16'd1, 16'h0190, 0, 1'b0);
        check_value("after_rst_result", mem[16'h0190], 8'd30);
        check_value("after_rst_done", done_cyc, 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
